// File: rtl/img_pkg.sv
// Shared pixel types, default frame geometry and small arithmetic helpers
// used by the image pipeline stages.
package img_pkg;

    typedef logic [7:0]  gray_t;
    typedef logic [23:0] rgb_t;

    localparam int unsigned IMG_W_DEFAULT = 320;
    localparam int unsigned IMG_H_DEFAULT = 240;
    localparam int unsigned SAT_DEFAULT   = 255;

    // Zero-extend a pixel into the signed 11-bit gradient domain.
    function automatic logic signed [10:0] px_ext(input gray_t p);
        return $signed({3'b000, p});
    endfunction

    // Magnitude of an 11-bit signed gradient, widened to 12 bits for summing.
    function automatic logic [11:0] abs11(input logic signed [10:0] v);
        logic [10:0] m;
        m = v[10] ? $unsigned(-v) : $unsigned(v);
        return {1'b0, m};
    endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// One line of pixel storage: synchronous write, combinational read at the
// same index, so a read-modify-write of one location fits in a single cycle.
module gray_line_buffer #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are never reset; the consumer masks stale data.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector with one registered output stage.
// Each accepted gray pixel produces one saturated |Gx|+|Gy| pixel for the
// centre one column left and one line up; border positions output zero.
module sobel_edge
    import img_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEFAULT,
    parameter int unsigned IMG_H = IMG_H_DEFAULT,
    parameter int unsigned SAT   = SAT_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    output logic  in_ready,
    input  gray_t in_gray,
    input  logic  in_sof,
    output logic  out_valid,
    input  logic  out_ready,
    output gray_t out_edge,
    output rgb_t  out_pix,
    output logic  out_sof,
    output logic  out_eol
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_valid;
    gray_t         r_edge;
    rgb_t          r_pix;
    logic          r_sof;
    logic          r_eol;
    gray_t [2:0][2:0] r_win;  // [row][col], row 0 = oldest line, col 0 = oldest column

    logic              w_accept;
    logic [XW-1:0]     w_px;
    logic [YW-1:0]     w_py;
    gray_t             w_lb0;
    gray_t             w_lb1;
    gray_t [2:0][2:0]  w_win;
    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic [11:0]       w_mag;
    gray_t             w_edge;
    logic              w_border;

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_valid;
    assign out_edge  = r_edge;
    assign out_pix   = r_pix;
    assign out_sof   = r_sof;
    assign out_eol   = r_eol;

    // A start-of-frame marker places this pixel at the origin regardless of the counters.
    assign w_px = in_sof ? '0 : r_x;
    assign w_py = in_sof ? '0 : r_y;

    // LB1 holds the previous line; LB0 takes over LB1's old value (two lines back).
    gray_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (8),
        .AW    (XW)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_px),
        .i_wdata (in_gray),
        .o_rdata (w_lb1)
    );

    gray_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (8),
        .AW    (XW)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_px),
        .i_wdata (w_lb1),
        .o_rdata (w_lb0)
    );

    // Advance the raster position on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_accept) begin
            if (w_px == X_LAST) begin
                r_x <= '0;
                r_y <= (w_py == Y_LAST) ? '0 : w_py + 1'b1;
            end else begin
                r_x <= w_px + 1'b1;
                r_y <= w_py;
            end
        end
    end

    // Window after this pixel's column shifts in; the kernel works on this view.
    always_comb begin
        w_win = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win[r][0] = r_win[r][1];
            w_win[r][1] = r_win[r][2];
        end
        w_win[0][2] = w_lb0;
        w_win[1][2] = w_lb1;
        w_win[2][2] = in_gray;
    end

    // Shift the new column into the window on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (w_accept) begin
            r_win <= w_win;
        end
    end

    // Sobel gradients, saturated magnitude and border masking.
    always_comb begin
        w_gx = (px_ext(w_win[0][2]) + (px_ext(w_win[1][2]) <<< 1) + px_ext(w_win[2][2]))
             - (px_ext(w_win[0][0]) + (px_ext(w_win[1][0]) <<< 1) + px_ext(w_win[2][0]));
        w_gy = (px_ext(w_win[2][0]) + (px_ext(w_win[2][1]) <<< 1) + px_ext(w_win[2][2]))
             - (px_ext(w_win[0][0]) + (px_ext(w_win[0][1]) <<< 1) + px_ext(w_win[0][2]));
        w_mag    = abs11(w_gx) + abs11(w_gy);
        w_border = (w_px < XW'(2)) || (w_py < YW'(2));
        if (w_border) begin
            w_edge = '0;
        end else if (w_mag > 12'(SAT)) begin
            w_edge = 8'(SAT);
        end else begin
            w_edge = w_mag[7:0];
        end
    end

    // Output register: load on accept, drop valid once consumed, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_edge  <= '0;
            r_pix   <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_edge  <= w_edge;
            r_pix   <= {w_edge, w_edge, w_edge};
            r_sof   <= (w_px == '0) && (w_py == '0);
            r_eol   <= (w_px == X_LAST);
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_edge.sv
// Self-checking bench for sobel_edge on an 8x6 frame: an image-level Sobel
// model plus hand-derived per-pattern values, checked on every output transfer.
module tb_sobel_edge;
    import img_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    logic  clk       = 1'b0;
    logic  rst_n     = 1'b0;
    logic  in_valid  = 1'b0;
    logic  in_ready;
    gray_t in_gray   = '0;
    logic  in_sof    = 1'b0;
    logic  out_valid;
    logic  out_ready = 1'b1;
    gray_t out_edge;
    rgb_t  out_pix;
    logic  out_sof;
    logic  out_eol;

    always #5 clk = ~clk;

    sobel_edge #(
        .IMG_W (W),
        .IMG_H (H),
        .SAT   (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gray   (in_gray),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_edge  (out_edge),
        .out_pix   (out_pix),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    typedef struct {
        int ev;
        int lit;
        bit sof;
        bit eol;
    } exp_t;

    exp_t q[$];
    int   img [H][W];
    int   mx = 0;
    int   my = 0;
    int   cur_kind = 0;
    int   stall_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   done = 1'b0;
    bit   timeout = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Sobel on the stored image, centre (x-1,y-1), zero on borders.
    function automatic int model_edge(input int x, input int y);
        int gx, gy, m;
        if (x < 2 || y < 2) return 0;
        gx = (img[y-2][x] + 2 * img[y-1][x] + img[y][x])
           - (img[y-2][x-2] + 2 * img[y-1][x-2] + img[y][x-2]);
        gy = (img[y][x-2] + 2 * img[y][x-1] + img[y][x])
           - (img[y-2][x-2] + 2 * img[y-2][x-1] + img[y-2][x]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // Hand-derived results: flat -> 0, step -> 255 at x=4,5, ramp -> 80 inside.
    function automatic int literal(input int kind, input int x, input int y);
        if (x < 2 || y < 2) return 0;
        if (kind == 1) return (x == 4 || x == 5) ? 255 : 0;
        if (kind == 2) return 80;
        return 0;
    endfunction

    // Single compare process: reset state, output transfers, stall freeze, model updates.
    initial begin : cmp
        exp_t  e;
        bit    held_v;
        gray_t h_e;
        rgb_t  h_p;
        logic  h_s, h_l;
        int    cyc, px, py;
        held_v = 1'b0;
        cyc    = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (done) break;
            cyc++;
            if (cyc > 30000) begin
                n_err++;
                $display("FAIL watchdog: got %0d cycles required below 30000", cyc);
                break;
            end
            if (!rst_n) begin
                #1;
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_out_edge", int'(out_edge), 0);
                check("rst_out_pix", int'(out_pix), 0);
                check("rst_out_sof", int'(out_sof), 0);
                check("rst_out_eol", int'(out_eol), 0);
                q.delete();
                mx     = 0;
                my     = 0;
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_edge", int'(out_edge), int'(h_e));
                    check("stall_pix", int'(out_pix), int'(h_p));
                    check("stall_flags", int'({out_sof, out_eol}), int'({h_s, h_l}));
                end
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", int'(in_ready), 0);
                    held_v = 1'b1;
                    h_e = out_edge;
                    h_p = out_pix;
                    h_s = out_sof;
                    h_l = out_eol;
                end else begin
                    held_v = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("extra_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("edge_model", int'(out_edge), e.ev);
                        check("edge_literal", int'(out_edge), e.lit);
                        check("pix", int'(out_pix), e.ev * 65793);
                        check("sof", int'(out_sof), int'(e.sof));
                        check("eol", int'(out_eol), int'(e.eol));
                    end
                end
                if (in_valid && in_ready) begin
                    px = in_sof ? 0 : mx;
                    py = in_sof ? 0 : my;
                    img[py][px] = int'(in_gray);
                    e.ev  = model_edge(px, py);
                    e.lit = literal(cur_kind, px, py);
                    e.sof = (px == 0 && py == 0);
                    e.eol = (px == W - 1);
                    q.push_back(e);
                    if (px == W - 1) begin
                        mx = 0;
                        my = (py == H - 1) ? 0 : py + 1;
                    end else begin
                        mx = px + 1;
                        my = py;
                    end
                end
            end
        end
        check("queue_drained", q.size(), 0);
        check("no_timeout", int'(timeout), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Present one pixel until accepted; out_ready follows the stall counter.
    task automatic send(input int v, input bit sof);
        int tries;
        bit acc;
        tries    = 0;
        in_valid = 1'b1;
        in_gray  = 8'(v);
        in_sof   = sof;
        do begin
            out_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 50);
        if (!acc) timeout = 1'b1;
    endtask

    // kind: 0 flat 100, 1 vertical step, 2 ramp 10*x; resync_at/stall_at < 0 disables.
    task automatic frame(input int kind, input int npix, input int resync_at, input int stall_at);
        int j, x, v;
        cur_kind = kind;
        for (int i = 0; i < npix; i++) begin
            j = (resync_at >= 0 && i >= resync_at) ? i - resync_at : i;
            x = j % W;
            if (kind == 0) v = 100;
            else if (kind == 1) v = (x < 4) ? 0 : 255;
            else v = 10 * x;
            if (i == stall_at) stall_cnt = 5;
            send(v, (i == 0) || (i == resync_at));
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin : stim
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame(0, 48, -1, -1);
        frame(1, 48, -1, -1);
        frame(2, 48, -1, -1);
        frame(2, 48, -1, 20);
        frame(2, 20, -1, -1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        frame(0, 48, -1, -1);
        frame(2, 13 + 48, 13, -1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 done = 1'b1;
    end

endmodule
